// File: rtl/fir_mc.sv
// Multi-channel time-multiplexed FIR: NC delay lines share one registered multiplier and accumulator.
// Define FIR_SAT_EN to make output narrowing saturate; otherwise it wraps.

module fir_mc_dline #(
  parameter int T  = 4,
  parameter int NI = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr_i,
  input  logic                  shift_i,
  input  logic [NI-1:0]         x_i,
  output logic [T-1:0][NI-1:0]  taps_o
);
  logic [T-1:0][NI-1:0] taps_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       taps_q <= '0;
    else if (clr_i)   taps_q <= '0;
    else if (shift_i) taps_q <= {taps_q[T-2:0], x_i};
  end

  assign taps_o = taps_q;
endmodule

module fir_mc #(
  parameter int T     = 4,
  parameter int NI    = 8,
  parameter int NW    = 8,
  parameter int NO    = 16,
  parameter int NC    = 2,
  parameter int SHIFT = 0,
  localparam int CW   = (NC > 1) ? $clog2(NC) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr_i,
  input  logic [T-1:0][NW-1:0]  w_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [CW-1:0]         in_ch_i,
  input  logic [NI-1:0]         x_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [CW-1:0]         out_ch_o,
  output logic [NO-1:0]         y_o
);
  localparam int NA = NI + NW + $clog2(T);
  localparam int NM = NI + NW;
  localparam int KW = $clog2(T + 1);
  localparam int KI = $clog2(T);
  localparam int MW = ((NA > NO) ? NA : NO) + 1;
  localparam logic signed [MW-1:0] YMAX = {{(MW-NO+1){1'b0}}, {(NO-1){1'b1}}};
  localparam logic signed [MW-1:0] YMIN = {{(MW-NO+1){1'b1}}, {(NO-1){1'b0}}};

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MAC  = 2'd1;
  localparam logic [1:0] S_OUT  = 2'd2;

  logic [1:0]              state_q, state_d;
  logic [KW-1:0]           k_q, k_d;
  logic [CW-1:0]           ch_q, ch_d;
  logic signed [NA-1:0]    acc_q, acc_d;
  logic signed [NM-1:0]    prod_q, prod_d;
  logic                    pv_q, pv_d;

  logic [NC-1:0][T-1:0][NI-1:0] dl;
  logic [NC-1:0]                shift;
  logic                         accept, ch_ok;
  logic [KI-1:0]                kidx;
  logic signed [NM-1:0]         mul;

  assign in_ready_o  = (state_q == S_IDLE) && !clr_i;
  assign accept      = in_valid_i && in_ready_o;
  assign ch_ok       = int'(in_ch_i) < NC;
  assign out_valid_o = (state_q == S_OUT);
  assign out_ch_o    = ch_q;

  for (genvar c = 0; c < NC; c++) begin : g_ch
    assign shift[c] = accept && ch_ok && (int'(in_ch_i) == c);
    fir_mc_dline #(.T(T), .NI(NI)) u_dline (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr_i   (clr_i),
      .shift_i (shift[c]),
      .x_i     (x_i),
      .taps_o  (dl[c])
    );
  end

  // Product is registered, so the accumulator trails issue by one cycle: k runs 0..T.
  assign kidx = k_q[KI-1:0];
  assign mul  = NM'($signed(w_i[kidx])) * NM'($signed(dl[ch_q][kidx]));

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    ch_d    = ch_q;
    acc_d   = acc_q;
    prod_d  = prod_q;
    pv_d    = pv_q;
    if (clr_i) begin
      state_d = S_IDLE;
      k_d     = '0;
      ch_d    = '0;
      acc_d   = '0;
      pv_d    = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (accept && ch_ok) begin
          state_d = S_MAC;
          k_d     = '0;
          ch_d    = in_ch_i;
          acc_d   = '0;
          pv_d    = 1'b0;
        end
        S_MAC: begin
          if (pv_q) acc_d = acc_q + NA'(prod_q);
          if (k_q == KW'(T)) begin
            state_d = S_OUT;
            pv_d    = 1'b0;
          end else begin
            prod_d = mul;
            pv_d   = 1'b1;
            k_d    = k_q + 1'b1;
          end
        end
        S_OUT: if (out_ready_i) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      ch_q    <= '0;
      acc_q   <= '0;
      prod_q  <= '0;
      pv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      ch_q    <= ch_d;
      acc_q   <= acc_d;
      prod_q  <= prod_d;
      pv_q    <= pv_d;
    end
  end

  // acc_q is frozen in OUT, so Y stays stable under backpressure.
  logic signed [NA-1:0] sh;
  logic signed [MW-1:0] sh_w;
  assign sh   = acc_q >>> SHIFT;
  assign sh_w = {{(MW-NA){sh[NA-1]}}, sh};

`ifdef FIR_SAT_EN
  assign y_o = (sh_w > YMAX) ? NO'(YMAX) :
               (sh_w < YMIN) ? NO'(YMIN) : NO'(sh_w);
`else
  assign y_o = NO'(sh_w);
`endif
endmodule

// File: tb/tb_fir_mc.sv
// Directed + randomized bench for fir_mc against a sum-of-products reference model.
// Two instances: A (NC=3, NO=16) for channel behaviour, B (NC=2, NO=8) for overflow narrowing.
module tb_fir_mc;
  localparam int T = 4, NI = 8, NW = 8, SHIFT = 0;
  localparam int NC_A = 3, NO_A = 16, NC_B = 2, NO_B = 8;

  logic clk = 1'b0, rst_n = 1'b0, clr = 1'b0;
  always #5 clk = ~clk;

  logic [T-1:0][NW-1:0] w_a, w_b;
  logic                 in_valid = 1'b0, out_ready = 1'b1;
  logic [1:0]           in_ch = '0;
  logic [NI-1:0]        x = '0;
  logic                 sel = 1'b0;

  logic rdy_a, rdy_b, ov_a, ov_b;
  logic [1:0] och_a;
  logic [0:0] och_b;
  logic signed [NO_A-1:0] y_a;
  logic signed [NO_B-1:0] y_b;

  fir_mc #(.T(T), .NI(NI), .NW(NW), .NO(NO_A), .NC(NC_A), .SHIFT(SHIFT)) u_a (
    .clk(clk), .rst_n(rst_n), .clr_i(clr), .w_i(w_a),
    .in_valid_i(in_valid && !sel), .in_ready_o(rdy_a), .in_ch_i(in_ch), .x_i(x),
    .out_valid_o(ov_a), .out_ready_i(out_ready), .out_ch_o(och_a), .y_o(y_a));

  fir_mc #(.T(T), .NI(NI), .NW(NW), .NO(NO_B), .NC(NC_B), .SHIFT(SHIFT)) u_b (
    .clk(clk), .rst_n(rst_n), .clr_i(clr), .w_i(w_b),
    .in_valid_i(in_valid && sel), .in_ready_o(rdy_b), .in_ch_i(in_ch[0:0]), .x_i(x),
    .out_valid_o(ov_b), .out_ready_i(out_ready), .out_ch_o(och_b), .y_o(y_b));

  logic in_ready, out_valid;
  logic [1:0] out_ch;
  logic signed [63:0] y_mux;
  assign in_ready  = sel ? rdy_b : rdy_a;
  assign out_valid = sel ? ov_b : ov_a;
  assign out_ch    = sel ? {1'b0, och_b} : och_a;
  assign y_mux     = sel ? {{56{y_b[NO_B-1]}}, y_b} : {{48{y_a[NO_A-1]}}, y_a};

  int checks = 0, errors = 0;
  longint hist [2][NC_A][T];
  longint wm [2][T];
  longint exp_y, exp_ch, last_y;

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic longint narrow(input longint s, input int no);
    longint lim = longint'(1) << (no - 1);
`ifdef FIR_SAT_EN
    if (s > lim - 1) return lim - 1;
    if (s < -lim) return -lim;
    return s;
`else
    longint m = s % (2 * lim);
    if (m < 0) m += 2 * lim;
    if (m >= lim) m -= 2 * lim;
    return m;
`endif
  endfunction

  function automatic longint ref_y(input int d, input int ch);
    longint s = 0;
    for (int k = 0; k < T; k++) s += wm[d][k] * hist[d][ch][k];
    return narrow(s >>> SHIFT, d ? NO_B : NO_A);
  endfunction

  task automatic load_w();
    for (int k = 0; k < T; k++) begin
      wm[0][k] = longint'($signed(w_a[k]));
      wm[1][k] = longint'($signed(w_b[k]));
    end
  endtask

  task automatic clear_model();
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < NC_A; c++)
        for (int k = 0; k < T; k++) hist[d][c][k] = 0;
  endtask

  task automatic model_push(input int ch, input int xv);
    int d = sel ? 1 : 0;
    if (ch < (sel ? NC_B : NC_A)) begin
      for (int k = T - 1; k > 0; k--) hist[d][ch][k] = hist[d][ch][k-1];
      hist[d][ch][0] = xv;
      exp_y  = ref_y(d, ch);
      exp_ch = ch;
    end
  endtask

  task automatic push(input int ch, input int xv);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    chk("push_ready", in_ready, 1);
    in_valid = 1'b1; in_ch = ch[1:0]; x = xv[NI-1:0];
    @(posedge clk); #1;
    in_valid = 1'b0;
    model_push(ch, xv);
  endtask

  task automatic get_out(input string tag);
    int lat = 0;
    while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    chk({tag, "_lat"}, lat, T + 1);
    chk({tag, "_y"}, y_mux, exp_y);
    chk({tag, "_ch"}, out_ch, exp_ch);
    last_y = y_mux;
    if (out_ready) begin
      @(posedge clk); #1;
      chk({tag, "_drop"}, out_valid, 0);
    end
  endtask

  initial begin
    int seen, ch, xv;
    w_a = {8'sd4, 8'sd3, -8'sd1, -8'sd2};
    w_b = {T{8'sd127}};
    load_w();
    clear_model();

    #12;
    chk("rst_valid", out_valid, 0);
    chk("rst_y", y_mux, 0);
    chk("rst_ch", out_ch, 0);
    @(negedge clk) rst_n = 1'b1;
    #1 chk("rst_ready", in_ready, 1);

    // impulse on ch0: W taps stream out one per sample
    push(0, 1); get_out("imp0"); chk("imp0_const", last_y, -2);
    for (int i = 0; i < 4; i++) begin push(0, 0); get_out("imp"); end
    chk("imp4_const", last_y, 0);

    // interleaved channels keep independent histories
    push(0, 1); get_out("il0"); chk("il0_const", last_y, -2);
    push(1, 2); get_out("il1"); chk("il1_const", last_y, -4);
    push(0, 0); get_out("il2"); chk("il2_const", last_y, -1);
    push(1, 0); get_out("il3"); chk("il3_const", last_y, -2);

    // backpressure: result held, pending sample not consumed
    out_ready = 1'b0;
    push(1, 7); get_out("bp");
    @(negedge clk); in_valid = 1'b1; in_ch = 2'd0; x = 8'd5;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("bp_y", y_mux, exp_y);
      chk("bp_ch", out_ch, exp_ch);
      chk("bp_valid", out_valid, 1);
      chk("bp_ready", in_ready, 0);
    end
    @(negedge clk) out_ready = 1'b1;
    @(posedge clk); #1 chk("bp_release", out_valid, 0);
    @(posedge clk); #1 in_valid = 1'b0;
    model_push(0, 5);
    get_out("bp2");

    // CLR in IDLE blocks acceptance
    @(negedge clk); clr = 1'b1; in_valid = 1'b1; in_ch = 2'd0; x = 8'd9;
    #1 chk("clr_ready", in_ready, 0);
    @(negedge clk); clr = 1'b0; in_valid = 1'b0;
    clear_model();
    for (int i = 0; i < 3; i++) begin push(0, 1); get_out("clr_hist"); end
    // CLR mid-MAC aborts the sample and wipes history
    push(0, 1);
    @(negedge clk) clr = 1'b1;
    @(negedge clk) clr = 1'b0;
    clear_model();
    seen = 0;
    for (int i = 0; i < 12; i++) begin @(posedge clk); #1; if (out_valid) seen = 1; end
    chk("clr_no_out", seen, 0);
    push(0, 1); get_out("clr_after"); chk("clr_after_const", last_y, -2);

    // out-of-range channel is swallowed
    push(3, 5);
    seen = 0;
    for (int i = 0; i < T + 4; i++) begin @(posedge clk); #1; if (out_valid) seen = 1; end
    chk("bad_no_out", seen, 0);
    chk("bad_ready", in_ready, 1);
    push(0, 0); get_out("bad_next");

    // reset during OUT kills the result
    out_ready = 1'b0;
    push(1, 3); get_out("rst_mid");
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid_valid", out_valid, 0);
    chk("rstmid_y", y_mux, 0);
    chk("rstmid_ch", out_ch, 0);
    @(negedge clk) rst_n = 1'b1;
    out_ready = 1'b1;
    clear_model();
    push(0, 1); get_out("rst_after"); chk("rst_after_const", last_y, -2);

    // randomized coefficients and traffic
    for (int k = 0; k < T; k++) w_a[k] = NW'($urandom_range(0, 255));
    load_w();
    for (int i = 0; i < 40; i++) begin
      ch = $urandom_range(0, 3);
      xv = int'($urandom_range(0, 255)) - 128;
      push(ch, xv);
      if (ch < NC_A) get_out("rnd");
      else begin
        repeat (T + 2) @(posedge clk);
        #1 chk("rnd_bad", out_valid, 0);
      end
    end

    // overflow on narrow instance
    sel = 1'b1;
    for (int i = 0; i < 4; i++) begin push(0, 127); get_out("ovf"); end
`ifdef FIR_SAT_EN
    chk("ovf_const", last_y, 127);
`else
    chk("ovf_const", last_y, 4);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
